ifu_fetch_queue: RTL and testbench

//  Parametrised PC generator plus in-order fetch queue, sitting between the F-stage and the

---
 rtl/ifu_pkg.sv | 31 +++
 rtl/ifu_fetch_ring.sv | 91 +++++++++
 rtl/ifu_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
// Optional build macro: IFU_ADEL_CHECK_EN adds a per-entry address-error flag.
package ifu_pkg;

    // Storage widths of a queue entry; top-level ADDR_W/INSTR_W must not exceed these.
    localparam int unsigned IFU_ADDR_W  = 32;
    localparam int unsigned IFU_INSTR_W = 32;

    localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h0000_3000;
    localparam logic [IFU_ADDR_W-1:0] IFU_EXC_PC   = 32'h0000_4180;

    typedef enum logic [1:0] {RD_NONE, RD_EXC, RD_ERET, RD_BR} redirect_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
        logic                   filled;
`ifdef IFU_ADEL_CHECK_EN
        logic                   adel;
`endif
    } fetch_entry_t;

    // Redirect source with fixed priority: exception > eret > branch/jump.
    function automatic redirect_e redirect_sel(input logic exc, input logic ret, input logic br);
        if (exc)       return RD_EXC;
        else if (ret)  return RD_ERET;
        else if (br)   return RD_BR;
        else           return RD_NONE;
    endfunction

endpackage

// File: rtl/ifu_fetch_ring.sv
// In-order ring of fetch entries: allocate at tail, fill the oldest unfilled entry,
// pop at head, clear everything on a redirect. Reports occupancy and unfilled counts.
// Optional build macro: IFU_ADEL_CHECK_EN (widens the stored entry only).
module ifu_fetch_ring
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   alloc,
    input  fetch_entry_t           alloc_entry,
    input  logic                   fill,
    input  logic [IFU_INSTR_W-1:0] fill_instr,
    input  logic                   pop,
    output fetch_entry_t           head_entry,
    output logic                   head_valid,
    output logic [PTR_W:0]         alloc_cnt,
    output logic [PTR_W:0]         unfilled_cnt
);

    fetch_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W:0]   head_q;
    logic [PTR_W:0]   tail_q;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             found;

    // Pointers carry a wrap bit so full (DEPTH) and empty (0) differ.
    assign head_idx   = head_q[PTR_W-1:0];
    assign tail_idx   = tail_q[PTR_W-1:0];
    assign alloc_cnt  = tail_q - head_q;
    assign head_valid = valid_q[head_idx];
    assign head_entry = entries[head_idx];

    // Locate the oldest unfilled entry (responses return in order) and count unfilled entries.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fill_idx     = head_idx;
        scan_idx     = head_idx;
        found        = 1'b0;
        unfilled_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_idx + PTR_W'(k);
            if (valid_q[scan_idx] && !entries[scan_idx].filled) begin
                unfilled_cnt = unfilled_cnt + 1'b1;
                if (!found) begin
                    fill_idx = scan_idx;
                    found    = 1'b1;
                end
            end
        end
    end

    // Control state: pointers and per-entry valid bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
        if (!reset || clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            if (alloc) begin
                valid_q[tail_idx] <= 1'b1;
                tail_q            <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= head_q + 1'b1;
            end
        end
    end

    // Entry payload: written on allocate and on response fill.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately not reset; valid_q qualifies every read of it.
        if (alloc) begin
            entries[tail_idx] <= alloc_entry;
        end
        if (fill) begin
            entries[fill_idx].instr  <= fill_instr;
            entries[fill_idx].filled <= 1'b1;
        end
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// PC generator plus in-order fetch queue between the F-stage and the instruction bus.
// Issues sequential fetches under a credit limit, applies redirects (exc > eret > branch)
// and discards responses still in flight from the abandoned stream.
// Optional build macro: IFU_ADEL_CHECK_EN adds out_adel; misaligned PCs then skip the bus.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter int unsigned       INSTR_W  = IFU_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(IFU_EXC_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exc_req,
    input  logic               eret,
    input  logic [ADDR_W-1:0]  epc,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
`ifdef IFU_ADEL_CHECK_EN
    output logic               out_adel,
`endif
    output logic [ADDR_W-1:0]  cur_pc
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    // Stale responses can outnumber DEPTH after back-to-back redirects; leave headroom.
    localparam int unsigned DROP_W = PTR_W + 3;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_pc;
    logic [DROP_W-1:0] drop_cnt;
    redirect_e         rd_sel;
    logic              flush;
    logic              credit;
    logic              misaligned;
    logic              issue;
    logic              alloc;
    logic              fill;
    logic              pop;
    logic [CNT_W-1:0]  alloc_cnt;
    logic [CNT_W-1:0]  unfilled_cnt;
    logic              head_valid;
    fetch_entry_t      alloc_entry;
    fetch_entry_t      head_entry;

    // Redirect target selection.
    always_comb begin
        rd_sel    = redirect_sel(exc_req, eret, br_valid);
        target_pc = pc_q;
        case (rd_sel)
            RD_EXC:  target_pc = EXC_PC;
            RD_ERET: target_pc = epc;
            RD_BR:   target_pc = br_pc;
            default: target_pc = pc_q;
        endcase
    end

    assign flush  = (rd_sel != RD_NONE);
    assign credit = (alloc_cnt < CNT_W'(DEPTH));

`ifdef IFU_ADEL_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign out_adel   = head_entry.adel;
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned PC (only detectable with the check enabled) takes a slot without a bus request.
    assign imem_req_valid = reset && !flush && credit && !misaligned;
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign alloc          = issue || (reset && !flush && credit && misaligned);
    assign fill           = reset && imem_rsp_valid && !flush && (drop_cnt == '0);

    // New tail entry: ordinary fetches wait for data, misaligned ones are complete at once.
    always_comb begin
        alloc_entry        = '0;
        alloc_entry.pc     = IFU_ADDR_W'(pc_q);
        alloc_entry.filled = misaligned;
`ifdef IFU_ADEL_CHECK_EN
        alloc_entry.adel   = misaligned;
`endif
    end

    assign out_valid = reset && head_valid && head_entry.filled && !flush;
    assign pop       = out_valid && out_ready;
    assign out_pc    = ADDR_W'(head_entry.pc);
    assign out_instr = INSTR_W'(head_entry.instr);
    assign cur_pc    = pc_q;

    ifu_fetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk          (clk),
        .reset        (reset),
        .clear        (flush),
        .alloc        (alloc),
        .alloc_entry  (alloc_entry),
        .fill         (fill),
        .fill_instr   (IFU_INSTR_W'(imem_rsp_data)),
        .pop          (pop),
        .head_entry   (head_entry),
        .head_valid   (head_valid),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    // PC sequencing and the count of old-stream responses still to be discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            drop_cnt <= '0;
        end else if (flush) begin
            pc_q     <= target_pc;
            // A response landing in the flush cycle belongs to the old stream.
            drop_cnt <= drop_cnt + DROP_W'(unfilled_cnt) - DROP_W'(imem_rsp_valid);
        end else begin
            if (alloc) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Every response must have a destination: a pending discard or an unfilled entry.
    assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> ((drop_cnt != '0) || (unfilled_cnt != '0)));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a small in-order bus model of configurable latency.
// Build with IFU_ADEL_CHECK_EN defined to exercise the misaligned-PC path.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_req, eret, br_valid;
    logic [31:0] epc, br_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_pc, out_instr;
    logic        out_ready;
    logic        out_adel;
    logic [31:0] cur_pc;

    ifu_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .exc_req        (exc_req),
        .eret           (eret),
        .epc            (epc),
        .br_valid       (br_valid),
        .br_pc          (br_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
`ifdef IFU_ADEL_CHECK_EN
        .out_adel       (out_adel),
`endif
        .cur_pc         (cur_pc)
    );

`ifndef IFU_ADEL_CHECK_EN
    assign out_adel = 1'b0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rsp_lat = 1;
    bit manual  = 1'b0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    // Outputs captured mid-cycle (negedge), away from the active edge.
    logic        s_req_valid, s_out_valid, s_out_adel;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr, s_cur_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock: sample outputs at negedge, pass the edge, then update the bus model.
    task automatic cycle();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_out_adel  = out_adel;
        s_cur_pc    = cur_pc;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!reset) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (!manual) begin
            if (fire) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc + rsp_lat - 1);
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0;
        epc = '0; br_pc = '0; imem_req_ready = 1'b1; out_ready = 1'b1;
        manual = 1'b0; rsp_lat = 1;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        cycle();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
        checks++; if (s_cur_pc !== 32'h3000) begin errors++; $display("FAIL reset_cur_pc: got %h want 00003000", s_cur_pc); end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h3000 + 32'(4*k)) begin
                errors++; $display("FAIL stream_req k=%0d: got v=%b a=%h want v=1 a=%h", k, s_req_valid, s_req_addr, 32'h3000 + 32'(4*k));
            end
            if (k >= 2) begin
                checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3000 + 32'(4*(k-2)) || s_out_instr !== instr_of(32'h3000 + 32'(4*(k-2)))) begin
                    errors++; $display("FAIL stream_out k=%0d: got v=%b pc=%h i=%h want pc=%h", k, s_out_valid, s_out_pc, s_out_instr, 32'h3000 + 32'(4*(k-2)));
                end
            end else begin
                checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL stream_early k=%0d: got out_valid=%b want 0", k, s_out_valid); end
            end
        end
        // Reset in the middle of a running stream.
        reset = 1'b0;
        cycle();
        checks++; if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got req=%b out=%b want 0 0", s_req_valid, s_out_valid); end
        cycle();
        reset = 1'b1;
        cycle();
        checks++; if (s_cur_pc !== 32'h3000 || s_out_valid !== 1'b0 || s_req_addr !== 32'h3000) begin
            errors++; $display("FAIL midreset_restart: got pc=%h out=%b addr=%h want 00003000 0 00003000", s_cur_pc, s_out_valid, s_req_addr);
        end
        cycle();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: got out_valid=%b want 0", s_out_valid); end
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3000) begin errors++; $display("FAIL midreset_first: got v=%b pc=%h want 1 00003000", s_out_valid, s_out_pc); end
    endtask

    task automatic test_credit();
        int fires;
        do_reset();
        out_ready = 1'b0;
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_req_valid) fires++;
        end
        checks++; if (fires !== 4) begin errors++; $display("FAIL credit_count: got %0d requests want 4", fires); end
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL credit_stall: got req_valid=%b want 0", s_req_valid); end
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3000) begin errors++; $display("FAIL credit_head: got v=%b pc=%h want 1 00003000", s_out_valid, s_out_pc); end
        out_ready = 1'b1;
        cycle();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL credit_no_bypass: got req_valid=%b want 0", s_req_valid); end
        out_ready = 1'b0;
        cycle();
        checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h3010 || s_out_pc !== 32'h3004) begin
            errors++; $display("FAIL credit_resume: got v=%b a=%h head=%h want 1 00003010 00003004", s_req_valid, s_req_addr, s_out_pc);
        end
    endtask

    task automatic test_branch_drop();
        do_reset();
        rsp_lat = 4;
        cycle(); cycle(); cycle();
        br_valid = 1'b1; br_pc = 32'h3040;
        cycle();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL br_flush_req: got req_valid=%b want 0", s_req_valid); end
        br_valid = 1'b0;
        cycle();
        checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h3040) begin errors++; $display("FAIL br_target: got v=%b a=%h want 1 00003040", s_req_valid, s_req_addr); end
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL br_stale k=%0d: got out_valid=%b pc=%h want 0", k, s_out_valid, s_out_pc); end
        end
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3040 || s_out_instr !== instr_of(32'h3040)) begin
            errors++; $display("FAIL br_first_out: got v=%b pc=%h i=%h want 1 00003040 %h", s_out_valid, s_out_pc, s_out_instr, instr_of(32'h3040));
        end
    endtask

    task automatic test_priority();
        do_reset();
        exc_req = 1'b1; eret = 1'b1; epc = 32'h3010; br_valid = 1'b1; br_pc = 32'h3040;
        cycle();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL prio_req: got req_valid=%b want 0", s_req_valid); end
        exc_req = 1'b0; br_valid = 1'b0;
        cycle();
        checks++; if (s_cur_pc !== 32'h4180) begin errors++; $display("FAIL prio_exc: got pc=%h want 00004180", s_cur_pc); end
        eret = 1'b0;
        cycle();
        checks++; if (s_cur_pc !== 32'h3010 || s_req_valid !== 1'b1 || s_req_addr !== 32'h3010) begin
            errors++; $display("FAIL prio_eret: got pc=%h v=%b a=%h want 00003010 1 00003010", s_cur_pc, s_req_valid, s_req_addr);
        end
        cycle();
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3010) begin errors++; $display("FAIL prio_out: got v=%b pc=%h want 1 00003010", s_out_valid, s_out_pc); end
    endtask

    task automatic test_flush_rsp();
        do_reset();
        manual = 1'b1;
        cycle();
        cycle();
        checks++; if (s_req_addr !== 32'h3004) begin errors++; $display("FAIL frsp_issue: got a=%h want 00003004", s_req_addr); end
        br_valid = 1'b1; br_pc = 32'h3080;
        imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'h3000);
        cycle();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL frsp_flush_req: got req_valid=%b want 0", s_req_valid); end
        br_valid = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'h3004);
        cycle();
        checks++; if (s_req_addr !== 32'h3080 || s_out_valid !== 1'b0) begin errors++; $display("FAIL frsp_target: got a=%h out=%b want 00003080 0", s_req_addr, s_out_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'h3080);
        cycle();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL frsp_dropped: got out_valid=%b want 0", s_out_valid); end
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3080 || s_out_instr !== instr_of(32'h3080)) begin
            errors++; $display("FAIL frsp_accept: got v=%b pc=%h i=%h want 1 00003080 %h", s_out_valid, s_out_pc, s_out_instr, instr_of(32'h3080));
        end
        manual = 1'b0;
    endtask

    task automatic test_unaligned();
        do_reset();
        out_ready = 1'b0;
        br_valid = 1'b1; br_pc = 32'h3002;
        cycle();
        br_valid = 1'b0;
        cycle();
        checks++; if (s_cur_pc !== 32'h3002) begin errors++; $display("FAIL unal_pc: got pc=%h want 00003002", s_cur_pc); end
`ifdef IFU_ADEL_CHECK_EN
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL adel_no_req: got req_valid=%b want 0", s_req_valid); end
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_adel !== 1'b1 || s_out_instr !== 32'h0 || s_out_pc !== 32'h3002) begin
            errors++; $display("FAIL adel_entry: got v=%b adel=%b i=%h pc=%h want 1 1 00000000 00003002", s_out_valid, s_out_adel, s_out_instr, s_out_pc);
        end
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL adel_next_no_req: got req_valid=%b want 0", s_req_valid); end
`else
        checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h3002) begin errors++; $display("FAIL unal_req: got v=%b a=%h want 1 00003002", s_req_valid, s_req_addr); end
        cycle();
        cycle();
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 32'h3002 || s_out_instr !== instr_of(32'h3002)) begin
            errors++; $display("FAIL unal_out: got v=%b pc=%h i=%h want 1 00003002 %h", s_out_valid, s_out_pc, s_out_instr, instr_of(32'h3002));
        end
`endif
    endtask

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_credit();
        test_branch_drop();
        test_priority();
        test_flush_rsp();
        test_unaligned();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
